// File: rtl/rotate_sequencer_pkg.sv
// Shared definitions for the iterative shift/rotate unit: op codes,
// FSM state encoding and default geometry.
package rotate_sequencer_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_AMT_W = 5;

    // Operation codes as issued by the control unit; 5..7 are reserved
    // and behave as pass-through.
    typedef enum logic [2:0] {
        OP_SHR  = 3'd0,
        OP_SHRA = 3'd1,
        OP_SHL  = 3'd2,
        OP_ROR  = 3'd3,
        OP_ROL  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rotate_sequencer_if.sv
// Start/busy/done handshake bundle between the control unit (master)
// and the shift/rotate sequencer (slave).
interface rotate_sequencer_if
    import rotate_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AMT_W = DEF_AMT_W
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, data_in, amount,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data_in, amount,
        output busy, done, result
    );
endinterface

// File: rtl/rotate_sequencer_step.sv
// rotate_step: one combinational step of the shift/rotate engine.
// Moves the working word by 1 bit, or by 4 bits when stride4_i is set.
// Reserved op codes leave the word unchanged.
module rotate_step
    import rotate_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             stride4_i,
    output logic [WIDTH-1:0] word_o
);

    // Select the next working word for the latched operation and stride.
    always_comb begin
        word_o = word_i;
        case (op_i)
            OP_SHR:  word_o = stride4_i ? {4'b0000, word_i[WIDTH-1:4]}
                                        : {1'b0, word_i[WIDTH-1:1]};
            OP_SHRA: word_o = stride4_i ? {{4{word_i[WIDTH-1]}}, word_i[WIDTH-1:4]}
                                        : {word_i[WIDTH-1], word_i[WIDTH-1:1]};
            OP_SHL:  word_o = stride4_i ? {word_i[WIDTH-5:0], 4'b0000}
                                        : {word_i[WIDTH-2:0], 1'b0};
            OP_ROR:  word_o = stride4_i ? {word_i[3:0], word_i[WIDTH-1:4]}
                                        : {word_i[0], word_i[WIDTH-1:1]};
            OP_ROL:  word_o = stride4_i ? {word_i[WIDTH-5:0], word_i[WIDTH-1:WIDTH-4]}
                                        : {word_i[WIDTH-2:0], word_i[WIDTH-1]};
            default: word_o = word_i;
        endcase
    end

endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: multi-cycle SHR/SHRA/SHL/ROR/ROL execution unit.
// A start in IDLE latches operand, count and op; RUN steps the working
// word until the count reaches zero, then the result register is loaded
// and done pulses for one cycle. Starts outside IDLE are dropped.
// Optional build macro ROTSEQ_FAST_STEP_EN: take 4-bit steps while the
// remaining count is at least 4 (same results, shorter latency).
module rotate_sequencer
    import rotate_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AMT_W = DEF_AMT_W
) (
    input  logic                clk,
    input  logic                clr,
    rotate_sequencer_if.slave   bus
);

    state_e           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] result_q;
    logic [AMT_W-1:0] cnt_q;
    logic [AMT_W-1:0] cnt_d;
    logic             busy_q;
    logic             done_q;
    logic             stride4;
    logic [WIDTH-1:0] step_word;

    // Choose the step stride and the count remaining after this step.
    always_comb begin
`ifdef ROTSEQ_FAST_STEP_EN
        stride4 = (cnt_q >= AMT_W'(4));
`else
        stride4 = 1'b0;
`endif
        cnt_d = stride4 ? (cnt_q - AMT_W'(4)) : (cnt_q - AMT_W'(1));
    end

    rotate_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i      (op_q),
        .word_i    (work_q),
        .stride4_i (stride4),
        .word_o    (step_word)
    );

    // Sequencer FSM with registered busy/done/result.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work_q  <= bus.data_in;
                        cnt_q   <= bus.amount;
                        op_q    <= bus.op;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '0) begin
                        work_q <= step_word;
                        cnt_q  <= cnt_d;
                    end else begin
                        result_q <= work_q;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Scoreboard bench for rotate_sequencer: the driver pushes the expected
// result and done cycle on every accepted start; a monitor pops and
// compares whenever done is seen, and checks the result is held otherwise.
module tb_rotate_sequencer;
    import rotate_sequencer_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;

    rotate_sequencer_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    rotate_sequencer #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] held     = '0;
    exp_t        exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour from plain shift arithmetic on the whole word.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] d,
                                            input int unsigned a);
        logic [31:0] r;
        case (op)
            3'd0: r = d >> a;
            3'd1: r = $signed(d) >>> a;
            3'd2: r = d << a;
            3'd3: r = (a == 0) ? d : ((d >> a) | (d << (32 - a)));
            3'd4: r = (a == 0) ? d : ((d << a) | (d >> (32 - a)));
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int unsigned step_cycles(input int unsigned a);
`ifdef ROTSEQ_FAST_STEP_EN
        return a / 4 + a % 4;
`else
        return a;
`endif
    endfunction

    // Monitor: compare on done, otherwise the result must be held.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_result"}, bus.result, e.res);
                    check({e.name, "_done_cycle"}, 32'(edge_n), 32'(e.cyc));
                    check({e.name, "_busy_in_done"}, {31'b0, bus.busy}, 32'd1);
                    held = e.res;
                end
            end else begin
                check("result_held", bus.result, held);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle (t=%0t)", $time);
        end
    endtask

    // Issue one operation at a negedge; the next posedge accepts it.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] a, input logic [31:0] res);
        exp_t e;
        wait_idle();
        bus.start   = 1'b1;
        bus.op      = op;
        bus.data_in = d;
        bus.amount  = a;
        e.res  = res;
        e.cyc  = edge_n + 1 + step_cycles(int'(a)) + 1;
        e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op      = 3'($urandom);
        bus.data_in = $urandom;
        bus.amount  = 5'($urandom);
        check({name, "_busy_after_accept"}, {31'b0, bus.busy}, 32'd1);
    endtask

    // Start pulse that must be ignored because the unit is not idle.
    task automatic stray_start();
        bus.start   = 1'b1;
        bus.op      = 3'($urandom);
        bus.data_in = $urandom;
        bus.amount  = 5'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] rd;
        logic [4:0]  ra;

        bus.start   = 1'b0;
        bus.op      = '0;
        bus.data_in = '0;
        bus.amount  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'b0, bus.busy}, 32'd0);
        check("reset_done",   {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        clr = 1'b1;
        @(negedge clk);

        issue("ror1",   OP_ROR,  32'h0000_0001, 5'd1,  32'h8000_0000);
        issue("rol8",   OP_ROL,  32'h0000_000F, 5'd8,  32'h0000_0F00);
        issue("shl31",  OP_SHL,  32'h0000_000F, 5'd31, 32'h8000_0000);
        issue("shra4",  OP_SHRA, 32'h8000_0000, 5'd4,  32'hF800_0000);
        issue("shr4",   OP_SHR,  32'h8000_0000, 5'd4,  32'h0800_0000);
        issue("ror9",   OP_ROR,  32'h0000_0001, 5'd9,  32'h0080_0000);
        issue("rsvd6",  3'd6,    32'hCAFE_F00D, 5'd7,  32'hCAFE_F00D);

        // Zero count, with starts in the RUN and DONE cycles that must drop.
        issue("ror0",   OP_ROR,  32'h1234_5678, 5'd0,  32'h1234_5678);
        stray_start();
        stray_start();
        issue("shl12",  OP_SHL,  32'h0000_0ABC, 5'd12, 32'h00AB_C000);
        repeat (3) stray_start();

        // Asynchronous reset in the middle of a long rotate.
        issue("abort",  OP_ROR,  32'hDEAD_BEEF, 5'd20, 32'h0);
        repeat (4) @(negedge clk);
        #2;
        clr = 1'b0;
        exp_q.delete();
        held = '0;
        #1;
        check("abort_busy",   {31'b0, bus.busy}, 32'd0);
        check("abort_done",   {31'b0, bus.done}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        repeat (25) @(negedge clk);
        issue("post_reset", OP_ROL, 32'h8000_0001, 5'd1, 32'h0000_0003);

        // Randomized traffic against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            rd  = $urandom;
            ra  = 5'($urandom_range(0, 31));
            issue("rand", rop, rd, ra, ref_res(rop, rd, int'(ra)));
            if ($urandom_range(0, 3) == 0) stray_start();
        end

        wait_idle();
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
